// File: rtl/roce_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : roce_read_responder
// Description : Accepts RDMA read commands on a meta stream, emits the read
//               response as 64-byte beats whose 8-byte lanes carry their own
//               remote address, then one completion status word per command.
// Revision    : 1.0 - initial release
// ============================================================================
module roce_read_responder #(
    parameter int C_S_AXIS_META_TDATA_WIDTH   = 256,
    parameter int C_M_AXIS_DATA_TDATA_WIDTH   = 512,
    parameter int C_M_AXIS_STATUS_TDATA_WIDTH = 512
) (
    input  logic                                       ap_clk,
    input  logic                                       areset,
    input  logic                                       s_axis_meta_tvalid,
    output logic                                       s_axis_meta_tready,
    input  logic [C_S_AXIS_META_TDATA_WIDTH-1:0]       s_axis_meta_tdata,
    input  logic [C_S_AXIS_META_TDATA_WIDTH/8-1:0]     s_axis_meta_tkeep,
    input  logic                                       s_axis_meta_tlast,
    output logic                                       m_axis_data_tvalid,
    input  logic                                       m_axis_data_tready,
    output logic [C_M_AXIS_DATA_TDATA_WIDTH-1:0]       m_axis_data_tdata,
    output logic [C_M_AXIS_DATA_TDATA_WIDTH/8-1:0]     m_axis_data_tkeep,
    output logic                                       m_axis_data_tlast,
    output logic                                       m_axis_status_tvalid,
    input  logic                                       m_axis_status_tready,
    output logic [C_M_AXIS_STATUS_TDATA_WIDTH-1:0]     m_axis_status_tdata,
    output logic [C_M_AXIS_STATUS_TDATA_WIDTH/8-1:0]   m_axis_status_tkeep,
    output logic                                       m_axis_status_tlast,
    output logic [31:0]                                rd_cmd_cnt,
    output logic [31:0]                                err_cnt,
    output logic                                       busy
);

    localparam int LANES      = C_M_AXIS_DATA_TDATA_WIDTH / 64;
    localparam int DATA_BYTES = C_M_AXIS_DATA_TDATA_WIDTH / 8;
    localparam int STATUS_W   = 156;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_STATUS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] qpn_q, qpn_d;
    logic [47:0] laddr_q, laddr_d;
    logic [47:0] raddr_q, raddr_d;
    logic [31:0] len_q, len_d;
    logic [3:0]  code_q, code_d;
    logic [47:0] addr_q, addr_d;      // remote address of the current beat
    logic [25:0] left_q, left_d;      // beats remaining after the current one
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    // Meta field decode
    logic [2:0]  meta_op;
    logic [23:0] meta_qpn;
    logic [47:0] meta_laddr;
    logic [47:0] meta_raddr;
    logic [31:0] meta_len;
    logic [32:0] nbeats_m1;           // ceil(len/64)-1, 33-bit so len=0xFFFFFFFF does not overflow
    logic        meta_fire;
    logic        data_fire;
    logic        status_fire;
    logic        data_vld;
    logic        status_vld;
    logic [DATA_BYTES-1:0] last_keep;
    logic [STATUS_W-1:0]   status_word;
    logic        meta_unused;

    assign meta_op    = s_axis_meta_tdata[2:0];
    assign meta_qpn   = s_axis_meta_tdata[26:3];
    assign meta_laddr = s_axis_meta_tdata[74:27];
    assign meta_raddr = s_axis_meta_tdata[122:75];
    assign meta_len   = s_axis_meta_tdata[154:123];
    assign nbeats_m1  = (({1'b0, meta_len} + 33'd63) >> 6) - 33'd1;

    assign meta_unused = ^{s_axis_meta_tkeep, s_axis_meta_tlast,
                           s_axis_meta_tdata[C_S_AXIS_META_TDATA_WIDTH-1:155],
                           nbeats_m1[32:26]};

    assign data_vld    = (state_q == S_DATA);
    assign status_vld  = (state_q == S_STATUS);
    assign meta_fire   = s_axis_meta_tvalid & s_axis_meta_tready;
    assign data_fire   = data_vld & m_axis_data_tready;
    assign status_fire = status_vld & m_axis_status_tready;

    // Next-state and command-context update
    always_comb begin
        state_d   = state_q;
        qpn_d     = qpn_q;
        laddr_d   = laddr_q;
        raddr_d   = raddr_q;
        len_d     = len_q;
        code_d    = code_q;
        addr_d    = addr_q;
        left_d    = left_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (meta_fire) begin
                    qpn_d   = meta_qpn;
                    laddr_d = meta_laddr;
                    raddr_d = meta_raddr;
                    len_d   = meta_len;
                    addr_d  = meta_raddr;
                    left_d  = nbeats_m1[25:0];
                    if (meta_op != 3'd0) begin
                        state_d = S_STATUS;
                        code_d  = 4'd1;
                    end else if (meta_len == 32'd0) begin
                        state_d = S_STATUS;
                        code_d  = 4'd2;
                    end else begin
                        state_d = S_DATA;
                        code_d  = 4'd0;
                    end
                end
            end
            S_DATA: begin
                if (data_fire) begin
                    if (left_q == 26'd0) begin
                        state_d = S_STATUS;
                        code_d  = 4'd0;
                    end else begin
                        left_d = left_q - 26'd1;
                        addr_d = addr_q + 48'd64;
                    end
                end
            end
            S_STATUS: begin
                if (status_fire) begin
                    state_d = S_IDLE;
                    if (code_q == 4'd0) rd_cnt_d  = rd_cnt_q + 32'd1;
                    else                err_cnt_d = err_cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any command in flight and clears counters
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            qpn_q     <= '0;
            laddr_q   <= '0;
            raddr_q   <= '0;
            len_q     <= '0;
            code_q    <= '0;
            addr_q    <= '0;
            left_q    <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            qpn_q     <= qpn_d;
            laddr_q   <= laddr_d;
            raddr_q   <= raddr_d;
            len_q     <= len_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Partial final beat keeps only the low len%64 bytes
    assign last_keep = (len_q[5:0] == 6'd0) ? {DATA_BYTES{1'b1}}
                     : (({{(DATA_BYTES-1){1'b0}}, 1'b1} << len_q[5:0]) - {{(DATA_BYTES-1){1'b0}}, 1'b1});

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign m_axis_data_tdata[64*k +: 64] = data_vld ? {16'h0, addr_q + 48'(8*k)} : 64'h0;
    end

    assign s_axis_meta_tready = (state_q == S_IDLE) && !areset;
    assign m_axis_data_tvalid = data_vld;
    assign m_axis_data_tlast  = data_vld && (left_q == 26'd0);
    assign m_axis_data_tkeep  = !data_vld ? '0 : ((left_q == 26'd0) ? last_keep : '1);

    assign status_word          = {code_q, len_q, raddr_q, laddr_q, qpn_q};
    assign m_axis_status_tvalid = status_vld;
    assign m_axis_status_tdata  = status_vld ? {{(C_M_AXIS_STATUS_TDATA_WIDTH-STATUS_W){1'b0}}, status_word} : '0;
    assign m_axis_status_tkeep  = status_vld ? '1 : '0;
    assign m_axis_status_tlast  = status_vld;

    assign rd_cmd_cnt = rd_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
